// File: rtl/sa_input_skewer.sv
// Feeder between the input FIFO and the systolic array: latches weight words, then diagonally skews input vectors.
// Optional FEEDER_STALL_CNT_EN adds stall_cnt_o, a saturating count of STREAM cycles with no valid input.

module sa_skew_lane #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DEPTH-1:0][DATA_W-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else if (adv) begin
            chain_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign dout = chain_q[DEPTH-1];
endmodule

module sa_input_skewer #(
    parameter int ARRAY_SIZE = 3,
    parameter int DATA_W     = 8,
    parameter int W_WORDS    = 3,
    parameter int N_VECS     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [31:0]                  s_data,
    output logic [W_WORDS*32-1:0]        w_o,
    output logic                         w_valid,
    output logic                         en_o,
    output logic [ARRAY_SIZE*DATA_W-1:0] in_o,
    output logic                         done_o,
    output logic                         busy_o
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt_o
`endif
);
    localparam int LW  = ARRAY_SIZE * DATA_W;
    localparam int WCW = $clog2(W_WORDS + 1);
    localparam int VCW = $clog2(N_VECS + 1);
    localparam int FCW = $clog2(2 * ARRAY_SIZE);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, FLUSH, DONE} state_t;

    state_t                      state_q, state_d;
    logic [WCW-1:0]              wcnt_q, wcnt_d;
    logic [VCW-1:0]              vcnt_q, vcnt_d;
    logic [FCW-1:0]              fcnt_q, fcnt_d;
    logic [W_WORDS-1:0][31:0]    w_q, w_d;
    logic                        wv_q, wv_d;
    logic                        en_q, done_q;
    logic                        accept, adv;
    logic [LW-1:0]               feed;

    assign s_ready = (state_q == LOAD_W) || (state_q == STREAM);
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        vcnt_d  = vcnt_q;
        fcnt_d  = fcnt_q;
        w_d     = w_q;
        wv_d    = wv_q;
        adv     = 1'b0;
        feed    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    wcnt_d  = '0;
                    vcnt_d  = '0;
                    fcnt_d  = '0;
                    w_d     = '0;
                    wv_d    = 1'b0;
                end
            end
            LOAD_W: begin
                if (accept) begin
                    for (int i = 0; i < W_WORDS; i++)
                        if (wcnt_q == WCW'(i)) w_d[i] = s_data;
                    wcnt_d = wcnt_q + WCW'(1);
                    if (wcnt_q == WCW'(W_WORDS - 1)) begin
                        wv_d    = 1'b1;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    adv    = 1'b1;
                    feed   = s_data[LW-1:0];
                    vcnt_d = vcnt_q + VCW'(1);
                    if (vcnt_q == VCW'(N_VECS - 1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // zeros push the last vector through the skew and the array itself
                adv    = 1'b1;
                fcnt_d = fcnt_q + FCW'(1);
                if (fcnt_q == FCW'(2 * ARRAY_SIZE - 2)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            vcnt_q  <= '0;
            fcnt_q  <= '0;
            w_q     <= '0;
            wv_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vcnt_q  <= vcnt_d;
            fcnt_q  <= fcnt_d;
            w_q     <= w_d;
            wv_q    <= wv_d;
            en_q    <= adv;
            // registered so the pulse lands after the final enable has been seen
            done_q  <= (state_q == DONE);
        end
    end

    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
        sa_skew_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (k + 1)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .adv  (adv),
            .din  (feed[k*DATA_W +: DATA_W]),
            .dout (in_o[k*DATA_W +: DATA_W])
        );
    end

    if (LW < 32) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^s_data[31:LW];
    end

    assign w_o     = w_q;
    assign w_valid = wv_q;
    assign en_o    = en_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != IDLE);

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (state_q == IDLE && start)
            stall_q <= '0;
        else if (state_q == STREAM && !s_valid && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt_o = stall_q;
`endif
endmodule
